// File: rtl/xbar_prog_pkg.sv
// -----------------------------------------------------------------------------
// xbar_prog_pkg
// Shared definitions for the crossbar cell programmer:
//   - prog_state_e : controller states (IDLE/PULSE/SETTLE/VERIFY/RESP)
//   - VAL_SET / VAL_RESET : target-state polarity (1 = low-resistance SET)
//   - idx_width / tries_width / timer_width : port and counter width helpers
// -----------------------------------------------------------------------------
package xbar_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_VERIFY,
    ST_RESP
  } prog_state_e;

  localparam logic VAL_SET   = 1'b1;
  localparam logic VAL_RESET = 1'b0;

  // Index width for a row/column address; a single row or column still
  // gets a 1-bit address port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width that holds the largest try count, MAX_RETRY+1.
  function automatic int tries_width(input int max_retry);
    return $clog2(max_retry + 2);
  endfunction

  // Width of the pulse/settle down-counter.
  function automatic int timer_width(input int pulse_cycles, input int settle_cycles);
    int longest;
    longest = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/xbar_pulse_timer.sv
// -----------------------------------------------------------------------------
// xbar_pulse_timer
// Loadable down-counter that times the PULSE and SETTLE phases.
//   clk, rst_n  : clock / asynchronous active-low reset
//   load        : load load_value this cycle (takes priority over counting)
//   load_value  : number of cycles in the phase minus one
//   expire      : high in the final cycle of the loaded phase (count == 0)
// A phase of N cycles is loaded with N-1 on the edge that enters it; the
// counter then holds at zero until the next load.
// -----------------------------------------------------------------------------
module xbar_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/xbar_cell_programmer.sv
// -----------------------------------------------------------------------------
// xbar_cell_programmer
// Write-side controller for the memristive crossbar. Accepts one program
// command at a time, pulses the addressed cell with SET or RESET, waits for
// the cell to settle, reads it back, and retries up to MAX_RETRY extra times
// before reporting the outcome.
//
// Ports
//   clk, rst_n           : clock / asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_row, cmd_col     : target cell address
//   cmd_val              : target state, 1 = SET, 0 = RESET
//   wl_sel, bl_sel       : one-hot wordline/bitline selects, zero when idle
//   set_pulse            : SET pulse enable
//   reset_pulse          : RESET pulse enable
//   read_en              : verify-read strobe
//   sense_in             : sensed cell state, sampled at the end of read_en
//   rsp_valid/rsp_ready  : status handshake
//   rsp_ok               : 1 = cell verified at target
//   rsp_tries            : pulses issued for this command
// -----------------------------------------------------------------------------
module xbar_cell_programmer
  import xbar_prog_pkg::*;
#(
  parameter int ROWS          = 2,
  parameter int COLS          = 4,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3,
  localparam int ROW_W = idx_width(ROWS),
  localparam int COL_W = idx_width(COLS),
  localparam int TRY_W = tries_width(MAX_RETRY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [COL_W-1:0] cmd_col,
  input  logic             cmd_val,
  output logic [ROWS-1:0]  wl_sel,
  output logic [COLS-1:0]  bl_sel,
  output logic             set_pulse,
  output logic             reset_pulse,
  output logic             read_en,
  input  logic             sense_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic [TRY_W-1:0] rsp_tries
);

  localparam int TMR_W = timer_width(PULSE_CYCLES, SETTLE_CYCLES);

  localparam logic [TMR_W-1:0] PULSE_LOAD  = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRIES_MAX   = TRY_W'(MAX_RETRY + 1);

  prog_state_e state_q, state_d;

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             val_q;
  logic [TRY_W-1:0] tries_q;
  logic             ok_q;

  logic             cmd_in_range;
  logic             accept;
  logic             verify_pass;
  logic             retry;
  logic             sel_active;
  logic             in_pulse;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expire;

  // ---------------------------------------------------------------------------
  // Phase timer
  // ---------------------------------------------------------------------------
  xbar_pulse_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expire     (tmr_expire)
  );

  // Addresses wider than the array (non-power-of-two ROWS/COLS) are rejected
  // without ever touching a select line.
  assign cmd_in_range = (int'(cmd_row) < ROWS) && (int'(cmd_col) < COLS);
  assign accept       = (state_q == ST_IDLE) && cmd_valid;
  assign verify_pass  = (state_q == ST_VERIFY) && (sense_in == val_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and timer control
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    retry     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_in_range) begin
            state_d   = ST_PULSE;
            tmr_load  = 1'b1;
            tmr_value = PULSE_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end

      ST_PULSE: begin
        if (tmr_expire) begin
          state_d   = ST_SETTLE;
          tmr_load  = 1'b1;
          tmr_value = SETTLE_LOAD;
        end
      end

      ST_SETTLE: begin
        if (tmr_expire) begin
          state_d = ST_VERIFY;
        end
      end

      ST_VERIFY: begin
        if (sense_in == val_q) begin
          state_d = ST_RESP;
        end else if (tries_q < TRIES_MAX) begin
          state_d   = ST_PULSE;
          tmr_load  = 1'b1;
          tmr_value = PULSE_LOAD;
          retry     = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, try counter and verify result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= VAL_RESET;
      tries_q <= '0;
      ok_q    <= 1'b0;
    end else if (accept) begin
      row_q   <= cmd_row;
      col_q   <= cmd_col;
      val_q   <= cmd_val;
      ok_q    <= 1'b0;
      // Entering PULSE counts as the first try; a rejected command reports 0.
      tries_q <= cmd_in_range ? TRY_W'(1) : '0;
    end else if (retry) begin
      if (tries_q != TRIES_MAX) begin
        tries_q <= tries_q + TRY_W'(1);
      end
    end else if (verify_pass) begin
      ok_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // NOTE: outputs are decoded combinationally from the asynchronously reset
  // state register, so selects and pulses fall the moment rst_n drops rather
  // than waiting for a clock edge.
  assign sel_active = (state_q == ST_PULSE) || (state_q == ST_SETTLE) ||
                      (state_q == ST_VERIFY);
  assign in_pulse   = (state_q == ST_PULSE);

  assign wl_sel      = sel_active ? (ROWS'(1) << row_q) : '0;
  assign bl_sel      = sel_active ? (COLS'(1) << col_q) : '0;
  assign set_pulse   = in_pulse && (val_q == VAL_SET);
  assign reset_pulse = in_pulse && (val_q == VAL_RESET);
  assign read_en     = (state_q == ST_VERIFY);

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_ok    = rsp_valid && ok_q;
  assign rsp_tries = rsp_valid ? tries_q : '0;

endmodule

// File: tb/tb_xbar_cell_programmer.sv
// -----------------------------------------------------------------------------
// tb_xbar_cell_programmer
// Directed bench for xbar_cell_programmer. Commands push their expected
// response into a scoreboard queue; a monitor pops and compares on every
// response handshake. Side monitors count pulse/read/select activity and
// flag invariant breaks. A second instance with 3x3 geometry exercises
// addresses that are representable but out of range.
// -----------------------------------------------------------------------------
module tb_xbar_cell_programmer;

  localparam int ROW_W = 1;
  localparam int COL_W = 2;
  localparam int TRY_W = 3;

  typedef struct {
    logic             ok;
    logic [TRY_W-1:0] tries;
    int               lat;
    int               acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ROW_W-1:0] cmd_row = '0;
  logic [COL_W-1:0] cmd_col = '0;
  logic             cmd_val = 1'b0;
  logic [1:0]       wl_sel;
  logic [3:0]       bl_sel;
  logic             set_pulse;
  logic             reset_pulse;
  logic             read_en;
  logic             sense_in = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_ok;
  logic [TRY_W-1:0] rsp_tries;

  // 3x3 instance for out-of-range addresses
  logic             o_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic [1:0]       o_cmd_row = '0;
  logic [1:0]       o_cmd_col = '0;
  logic             o_cmd_val = 1'b1;
  logic [2:0]       o_wl_sel;
  logic [2:0]       o_bl_sel;
  logic             o_set_pulse;
  logic             o_reset_pulse;
  logic             o_read_en;
  logic             o_sense_in = 1'b0;
  logic             o_rsp_valid;
  logic             o_rsp_ready = 1'b1;
  logic             o_rsp_ok;
  logic [TRY_W-1:0] o_rsp_tries;

  xbar_cell_programmer u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .cmd_val     (cmd_val),
    .wl_sel      (wl_sel),
    .bl_sel      (bl_sel),
    .set_pulse   (set_pulse),
    .reset_pulse (reset_pulse),
    .read_en     (read_en),
    .sense_in    (sense_in),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_ok      (rsp_ok),
    .rsp_tries   (rsp_tries)
  );

  xbar_cell_programmer #(
    .ROWS(3),
    .COLS(3)
  ) u_oor (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (o_cmd_valid),
    .cmd_ready   (o_cmd_ready),
    .cmd_row     (o_cmd_row),
    .cmd_col     (o_cmd_col),
    .cmd_val     (o_cmd_val),
    .wl_sel      (o_wl_sel),
    .bl_sel      (o_bl_sel),
    .set_pulse   (o_set_pulse),
    .reset_pulse (o_reset_pulse),
    .read_en     (o_read_en),
    .sense_in    (o_sense_in),
    .rsp_valid   (o_rsp_valid),
    .rsp_ready   (o_rsp_ready),
    .rsp_ok      (o_rsp_ok),
    .rsp_tries   (o_rsp_tries)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sense model: drives the planned read-back value during each verify read
  // ---------------------------------------------------------------------------
  logic [7:0] plan_q = '0;
  logic       sense_idle = 1'b0;
  int         vidx = 0;
  int         vbase = 0;

  always @(negedge clk) begin
    if (read_en) begin
      sense_in = plan_q[(vidx - vbase) & 7];
      vidx++;
    end else begin
      sense_in = sense_idle;
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor / scoreboard
  // ---------------------------------------------------------------------------
  bit rsp_seen = 1'b0;
  int last_hs = 0;
  int last_acc = 0;
  int rsp_any = 0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_any++;
      if (sb_q.size() == 0) begin
        if (!rsp_seen) check("unexpected_rsp", 32'(rsp_valid), 0);
        rsp_seen = !rsp_ready;
      end else begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          check("rsp_latency", cyc - sb_q[0].acc, sb_q[0].lat);
        end
        if (rsp_ready) begin
          check("rsp_ok", 32'(rsp_ok), 32'(sb_q[0].ok));
          check("rsp_tries", 32'(rsp_tries), 32'(sb_q[0].tries));
          void'(sb_q.pop_front());
          rsp_seen = 1'b0;
          last_hs  = cyc;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Activity counters and invariant watch
  // ---------------------------------------------------------------------------
  logic [1:0] exp_wl = '0;
  logic [3:0] exp_bl = '0;
  int set_cyc = 0, rst_cyc = 0, set_burst = 0, rst_burst = 0;
  int read_cyc = 0, sel_cyc = 0, sel_bad = 0, inv_bad = 0, o_act = 0;
  logic prev_set = 1'b0, prev_rst = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (set_pulse) set_cyc++;
      if (reset_pulse) rst_cyc++;
      if (set_pulse && !prev_set) set_burst++;
      if (reset_pulse && !prev_rst) rst_burst++;
      prev_set = set_pulse;
      prev_rst = reset_pulse;
      if (read_en) read_cyc++;
      if (wl_sel != '0) begin
        sel_cyc++;
        if (wl_sel !== exp_wl || bl_sel !== exp_bl) sel_bad++;
      end else if (bl_sel != '0) begin
        sel_bad++;
      end
      if (set_pulse && reset_pulse) inv_bad++;
      if ((set_pulse || reset_pulse || read_en) && (wl_sel == '0 || bl_sel == '0)) inv_bad++;
      if ($countones(wl_sel) > 1 || $countones(bl_sel) > 1) inv_bad++;
      if (rsp_valid && (wl_sel != '0 || bl_sel != '0)) inv_bad++;
      if (rsp_valid && cmd_ready) inv_bad++;
      if (o_wl_sel != '0 || o_bl_sel != '0 || o_set_pulse || o_reset_pulse || o_read_en) o_act++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_plan(input logic val, input logic [7:0] plan);
    plan_q     = plan;
    vbase      = vidx;
    sense_idle = ~val;
  endtask

  task automatic send_cmd(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                          input logic val, input exp_t e);
    int n = 0;
    @(posedge clk);
    #1;
    cmd_row   = row;
    cmd_col   = col;
    cmd_val   = val;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 1);
    e.acc    = cyc;
    last_acc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, sb_q.size(), 0);
  endtask

  task automatic run_case(input string tag, input logic [ROW_W-1:0] row,
                          input logic [COL_W-1:0] col, input logic val,
                          input logic [7:0] plan, input logic ok, input int tries,
                          input int lat, input int pulse_cyc, input int sel_exp);
    exp_t e;
    int b_set, b_rst, b_setb, b_rstb, b_read, b_sel;
    set_plan(val, plan);
    exp_wl = 2'b01 << row;
    exp_bl = 4'b0001 << col;
    b_set = set_cyc;   b_rst = rst_cyc;   b_setb = set_burst;
    b_rstb = rst_burst; b_read = read_cyc; b_sel = sel_cyc;
    e = '{ok: ok, tries: TRY_W'(tries), lat: lat, acc: 0};
    send_cmd(row, col, val, e);
    wait_drain(tag);
    if (val) begin
      check({tag, "_set_cycles"}, set_cyc - b_set, pulse_cyc);
      check({tag, "_reset_cycles"}, rst_cyc - b_rst, 0);
      check({tag, "_set_bursts"}, set_burst - b_setb, tries);
    end else begin
      check({tag, "_reset_cycles"}, rst_cyc - b_rst, pulse_cyc);
      check({tag, "_set_cycles"}, set_cyc - b_set, 0);
      check({tag, "_reset_bursts"}, rst_burst - b_rstb, tries);
    end
    check({tag, "_reads"}, read_cyc - b_read, tries);
    check({tag, "_sel_cycles"}, sel_cyc - b_sel, sel_exp);
  endtask

  task automatic oor_case(input string tag, input logic [1:0] row, input logic [1:0] col);
    @(posedge clk);
    #1;
    o_cmd_row   = row;
    o_cmd_col   = col;
    o_cmd_valid = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, 32'(o_cmd_ready), 1);
    @(posedge clk);
    #1 o_cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rsp"}, {o_rsp_valid, o_rsp_ok, o_rsp_tries}, {1'b1, 1'b0, 3'd0});
    @(negedge clk);
    check({tag, "_back_idle"}, {o_cmd_ready, o_rsp_valid}, 2'b10);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    int   n;
    int   b_rsp;

    // Reset values
    #12;
    check("rst_outputs_zero",
          {wl_sel, bl_sel, set_pulse, reset_pulse, read_en, rsp_valid, rsp_ok, rsp_tries}, 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {cmd_ready, rsp_valid}, 2'b10);

    // First-try success: 4 pulse + 2 settle + 1 verify + 1 -> rsp at +8
    run_case("first_try", 1'b1, 2'd2, 1'b1, 8'b0000_0001, 1'b1, 1, 8, 4, 7);

    // Two failed verifies then success: 3 tries, latency 8 + 2*7
    run_case("retry", 1'b0, 2'd3, 1'b0, 8'b0000_0011, 1'b1, 3, 22, 12, 21);

    // Sense stuck at 0 for a SET: 4 tries, latency 8 + 3*7
    run_case("exhaust", 1'b1, 2'd1, 1'b1, 8'b0000_0000, 1'b0, 4, 29, 16, 28);

    // Response backpressure with a competing command held on cmd_valid
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    set_plan(1'b1, 8'b0000_0001);
    exp_wl = 2'b10;
    exp_bl = 4'b0001;
    e = '{ok: 1'b1, tries: 3'd1, lat: 8, acc: 0};
    send_cmd(1'b1, 2'd0, 1'b1, e);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cmd_row   = 1'b0;
      cmd_col   = 2'd1;
      cmd_val   = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_ok, rsp_tries, cmd_ready}, {1'b1, 1'b1, 3'd1, 1'b0});
    end
    set_plan(1'b0, 8'b0000_0000);
    exp_wl = 2'b01;
    exp_bl = 4'b0010;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    e = '{ok: 1'b1, tries: 3'd1, lat: 8, acc: 0};
    send_cmd(1'b0, 2'd1, 1'b0, e);
    check("b2b_idle_gap", last_acc - last_hs, 1);
    wait_drain("bp");

    // Out-of-range addresses on the 3x3 instance
    oor_case("oor_col", 2'd0, 2'd3);
    oor_case("oor_row", 2'd3, 2'd0);
    check("oor_no_activity", o_act, 0);

    // Reset during the second PULSE cycle
    set_plan(1'b1, 8'b0000_0001);
    exp_wl = 2'b10;
    exp_bl = 4'b0100;
    e = '{ok: 1'b1, tries: 3'd1, lat: 8, acc: 0};
    send_cmd(1'b1, 2'd2, 1'b1, e);
    @(posedge clk);
    #2;
    check("pre_reset_pulse", {set_pulse, wl_sel, bl_sel}, {1'b1, 2'b10, 4'b0100});
    rst_n = 1'b0;
    #1;
    check("async_drop", {set_pulse, reset_pulse, wl_sel, bl_sel}, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b_rsp = rsp_any;
    @(negedge clk);
    check("post_abort_ready", 32'(cmd_ready), 1);
    repeat (12) @(negedge clk);
    check("post_abort_no_rsp", rsp_any - b_rsp, 0);

    // Whole-run invariants
    check("invariants", inv_bad, 0);
    check("select_pattern", sel_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
